pll_div_bank: RTL and testbench

//   Parametrised, fully synchronous clock-divider bank; successor to the fixed 3-output PLL wrapper.

---
 rtl/pll_div_bank.sv | 121 ++++++++++++
 tb/tb_pll_div_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_div_bank.sv
// rtl/pll_div_bank.sv - clock-divider bank with runtime ratio/phase reprogramming and lock detect
// Optional macro CLKEN_OUT_EN adds per-channel clock-enable pulses on port ce.
module pll_div_bank #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 16,
  parameter int DEF_DIV     = 2,
  parameter int DEF_PHASE   = 0,
  parameter int LOCK_CYCLES = 1000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LC_W = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              inclk0,
  input  logic              areset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] c,
`ifdef CLKEN_OUT_EN
  output logic [NUM_CH-1:0] ce,
`endif
  output logic              locked
);

  logic [CNT_W-1:0] div_q [NUM_CH];
  logic [CNT_W-1:0] div_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] c_q, c_d, wrap, hit;
  logic [LC_W-1:0]  lock_cnt_q;
  logic             locked_q, areset_q, err_q;
  logic             pend_q;
  logic [CH_W-1:0]  pend_ch_q;
  logic [CNT_W-1:0] pend_div_q, pend_phase_q;
  logic             accept, bad, apply;

  assign cfg_ready = !areset_q && !pend_q;
  assign cfg_err   = err_q;
  assign c         = c_q;
  assign locked    = locked_q;

  // A pending update replaces the wrap of its channel, so every period completes before the switch.
  always_comb begin
    accept = cfg_valid && cfg_ready;
    bad    = (int'(cfg_ch) >= NUM_CH) || (cfg_div < CNT_W'(2)) || (cfg_phase >= cfg_div);
    apply  = 1'b0;
    wrap   = '0;
    hit    = '0;
    c_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]    = (cnt_q[i] == div_q[i] - CNT_W'(1));
      hit[i]     = pend_q && (int'(pend_ch_q) == i) && wrap[i];
      cnt_nxt[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
      if (hit[i]) begin
        div_d[i] = pend_div_q;
        cnt_d[i] = pend_phase_q;
        c_d[i]   = (pend_phase_q < (pend_div_q >> 1));
      end else begin
        div_d[i] = div_q[i];
        cnt_d[i] = cnt_nxt[i];
        c_d[i]   = (cnt_nxt[i] < (div_q[i] >> 1));
      end
      apply = apply | hit[i];
    end
  end

  always_ff @(posedge inclk0) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= CNT_W'(DEF_DIV);
        cnt_q[i] <= CNT_W'(DEF_PHASE);
      end
      c_q          <= '0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      areset_q     <= 1'b1;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      c_q      <= c_d;
      areset_q <= 1'b0;
      err_q    <= accept && bad;
      if (accept && !bad) begin
        pend_q       <= 1'b1;
        pend_ch_q    <= cfg_ch;
        pend_div_q   <= cfg_div;
        pend_phase_q <= cfg_phase;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
      if (apply) begin
        lock_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        if (lock_cnt_q < LC_W'(LOCK_CYCLES)) lock_cnt_q <= lock_cnt_q + LC_W'(1);
        locked_q <= (lock_cnt_q == LC_W'(LOCK_CYCLES));
      end
    end
  end

`ifdef CLKEN_OUT_EN
  logic [NUM_CH-1:0] ce_q;
  assign ce = ce_q;

  always_ff @(posedge inclk0) begin
    if (areset) ce_q <= '0;
    else        ce_q <= wrap | hit;
  end
`endif

endmodule

// File: tb/tb_pll_div_bank.sv
// tb/tb_pll_div_bank.sv - scoreboard bench for pll_div_bank against a period-pattern reference model
module tb_pll_div_bank;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;
  localparam int LOCK   = 1000;

  logic              inclk0 = 1'b0;
  logic              areset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] c;
  logic [NUM_CH-1:0] ce_w;
  logic              locked;

  pll_div_bank dut (
    .inclk0(inclk0), .areset(areset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .c(c),
`ifdef CLKEN_OUT_EN
    .ce(ce_w),
`endif
    .locked(locked)
  );
`ifndef CLKEN_OUT_EN
  assign ce_w = '0;
`endif

  always #10 inclk0 = ~inclk0;

  typedef struct packed {
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] ce;
    logic              locked;
    logic              ready;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: each channel holds the queue of output bits still due in its current period.
  bit   m_bits[NUM_CH][$];
  int   m_div[NUM_CH];
  logic [NUM_CH-1:0] m_c, m_ce;
  bit   m_pend, m_first, m_acc, m_err, m_started;
  int   p_ch, p_div, p_ph, m_since;

  function automatic void load(int ch, int dv, int from);
    for (int p = from; p < dv; p++) m_bits[ch].push_back(p < dv / 2);
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  always @(posedge inclk0) begin : model
    exp_t e;
    bit rdy;
    bit applied;
    int ich, idv, iph;
    if (areset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_div[ch] = 2;
        m_bits[ch].delete();
        load(ch, 2, 1);
      end
      m_c = '0; m_ce = '0;
      m_pend = 0; m_first = 1; m_since = 0; m_acc = 0; m_err = 0; m_started = 1;
    end else if (m_started) begin
      rdy = !m_first && !m_pend;
      m_acc = cfg_valid && rdy;
      ich = int'(cfg_ch); idv = int'(cfg_div); iph = int'(cfg_phase);
      applied = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_ce[ch] = 1'b0;
        if (m_bits[ch].size() == 0) begin
          m_ce[ch] = 1'b1;
          if (m_pend && p_ch == ch) begin
            m_div[ch] = p_div;
            load(ch, p_div, p_ph);
            applied = 1;
          end else begin
            load(ch, m_div[ch], 0);
          end
        end
        m_c[ch] = m_bits[ch].pop_front();
      end
      if (applied) begin
        m_pend = 0;
        m_since = 0;
      end else if (m_since <= LOCK) begin
        m_since++;
      end
      m_err = 0;
      if (m_acc) begin
        if (ich >= NUM_CH || idv < 2 || iph >= idv) m_err = 1;
        else begin
          m_pend = 1; p_ch = ich; p_div = idv; p_ph = iph;
        end
      end
      m_first = 0;
    end
    if (m_started) begin
      e.c = m_c;
      e.ce = m_ce;
      e.locked = (m_since > LOCK);
      e.ready = !m_first && !m_pend;
      e.err = m_err;
      exp_q.push_back(e);
    end
  end

  always @(negedge inclk0) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("c", 32'(c), 32'(e.c));
      chk("locked", 32'(locked), 32'(e.locked));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
`ifdef CLKEN_OUT_EN
      chk("ce", 32'(ce_w), 32'(e.ce));
`endif
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge inclk0);
    #1;
  endtask

  task automatic send(input int ch, input int dv, input int ph);
    int n;
    cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv); cfg_phase = CNT_W'(ph);
    cfg_valid = 1'b1;
    n = 0;
    do begin
      @(posedge inclk0); #1; n++;
    end while (!m_acc && n < 300);
    cfg_valid = 1'b0;
    checks++;
    if (!m_acc) begin
      fails++;
      $display("FAIL handshake: request ch%0d not accepted within %0d cycles", ch, n);
    end
  endtask

  task automatic wait_apply();
    int n;
    n = 0;
    while (m_pend && n < 100) begin
      @(posedge inclk0); #1; n++;
    end
    checks++;
    if (m_pend) begin
      fails++;
      $display("FAIL apply: update still pending after %0d cycles", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ch, dv, ph;
    cycles(10);
    areset = 1'b0;
    cycles(1010);
    send(1, 5, 0);
    wait_apply();
    cycles(20);
    send(0, 1, 0);
    cycles(3);
    send(3, 5, 0);
    cycles(3);
    send(2, 4, 4);
    cycles(10);
    send(2, 8, 3);
    send(0, 3, 1);
    wait_apply();
    cycles(30);
    for (int k = 0; k < 30; k++) begin
      ch = $urandom_range(0, 3);
      dv = $urandom_range(0, 12);
      ph = $urandom_range(0, dv + 1);
      send(ch, dv, ph);
      cycles($urandom_range(0, 25));
    end
    wait_apply();
    cycles(5);
    send(0, 12, 0);
    areset = 1'b1;
    cycles(1);
    areset = 1'b0;
    cycles(1010);
    send(2, 7, 2);
    wait_apply();
    cycles(40);
    chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
